// File: rtl/ioport_bus_master_if.sv
// Command/response handshake and port-bus signals of the I/O port bus master.
// The master modport is the initiator side; the slave modport is the command source and bus responder.
interface ioport_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_port;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       irq_en;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] irq_count;
  logic       irq_stuck;

  modport master (
    input  cmd_valid, cmd_op, cmd_port, cmd_data, irq_en, in_port, interrupt,
    output cmd_ready, rsp_valid, rsp_data, port_id, out_port,
           write_strobe, k_write_strobe, read_strobe,
           interrupt_ack, irq_count, irq_stuck
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_port, cmd_data, irq_en, in_port, interrupt,
    input  cmd_ready, rsp_valid, rsp_data, port_id, out_port,
           write_strobe, k_write_strobe, read_strobe,
           interrupt_ack, irq_count, irq_stuck
  );
endinterface

// File: rtl/ioport_bus_master.sv
// KCPSM6-timed port-bus initiator: runs read/write/constant-write commands as
// two-cycle bus cycles with a one-cycle response, and acknowledges level interrupts.
module ioport_bus_master #(
  parameter int unsigned POST_GAP  = 0,
  parameter int unsigned IWAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  ioport_bus_master_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, STRB, RESP, GAP, IACK, IWAIT
  } state_e;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_KWRITE = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  localparam logic [3:0] GAP_LAST   = 4'(POST_GAP - 1);
  localparam logic [7:0] IWAIT_LAST = 8'(IWAIT_MAX);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  op_e        cmd_op;
  logic [7:0] port_id_q, port_id_d;
  logic [7:0] out_port_q, out_port_d;
  logic [7:0] rdata_q, rdata_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] iwait_cnt_q, iwait_cnt_d;
  logic [7:0] irq_count_q, irq_count_d;
  logic       irq_stuck_q, irq_stuck_d;
  logic       irq_take;

  assign cmd_op   = op_e'(bus.cmd_op);
  assign irq_take = bus.irq_en & bus.interrupt & ~irq_stuck_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    op_d        = op_q;
    port_id_d   = port_id_q;
    out_port_d  = out_port_q;
    rdata_d     = rdata_q;
    gap_cnt_d   = gap_cnt_q;
    iwait_cnt_d = iwait_cnt_q;
    irq_count_d = irq_count_q;
    irq_stuck_d = irq_stuck_q;

    case (state_q)
      IDLE: begin
        // A pending interrupt wins over a command; the command simply waits.
        if (irq_take) begin
          state_d = IACK;
        end else if (bus.cmd_valid) begin
          op_d    = cmd_op;
          state_d = ADDR;
          if (cmd_op != OP_NOP) port_id_d = bus.cmd_port;
          if (cmd_op == OP_WRITE || cmd_op == OP_KWRITE) out_port_d = bus.cmd_data;
        end
      end
      ADDR: state_d = (op_q == OP_NOP) ? RESP : STRB;
      STRB: begin
        if (op_q == OP_READ) rdata_d = bus.in_port;
        state_d = RESP;
      end
      RESP: begin
        gap_cnt_d = 4'd0;
        state_d   = (POST_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      IACK: begin
        if (irq_count_q != 8'hFF) irq_count_d = irq_count_q + 8'd1;
        iwait_cnt_d = 8'd0;
        state_d     = IWAIT;
      end
      IWAIT: begin
        // Hold off re-triggering until the level interrupt is released or declared stuck.
        if (!bus.interrupt) begin
          state_d = IDLE;
        end else if (iwait_cnt_q + 8'd1 == IWAIT_LAST) begin
          irq_stuck_d = 1'b1;
          state_d     = IDLE;
        end else begin
          iwait_cnt_d = iwait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      port_id_q   <= 8'h00;
      out_port_q  <= 8'h00;
      rdata_q     <= 8'h00;
      gap_cnt_q   <= 4'd0;
      iwait_cnt_q <= 8'd0;
      irq_count_q <= 8'd0;
      irq_stuck_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      port_id_q   <= port_id_d;
      out_port_q  <= out_port_d;
      rdata_q     <= rdata_d;
      gap_cnt_q   <= gap_cnt_d;
      iwait_cnt_q <= iwait_cnt_d;
      irq_count_q <= irq_count_d;
      irq_stuck_q <= irq_stuck_d;
    end
  end

  assign bus.cmd_ready      = (state_q == IDLE) & ~irq_take & ~rst;
  assign bus.rsp_valid      = (state_q == RESP);
  assign bus.rsp_data       = (state_q == RESP && op_q == OP_READ) ? rdata_q : 8'h00;
  assign bus.port_id        = port_id_q;
  assign bus.out_port       = out_port_q;
  assign bus.read_strobe    = (state_q == STRB) && (op_q == OP_READ);
  assign bus.write_strobe   = (state_q == STRB) && (op_q == OP_WRITE);
  assign bus.k_write_strobe = (state_q == STRB) && (op_q == OP_KWRITE);
  assign bus.interrupt_ack  = (state_q == IACK);
  assign bus.irq_count      = irq_count_q;
  assign bus.irq_stuck      = irq_stuck_q;

endmodule

// File: tb/tb_ioport_bus_master.sv
// Directed bench for ioport_bus_master: one DUT with POST_GAP=0 and one with POST_GAP=3.
// Inputs change and outputs are sampled mid-cycle (negedge + 1).
module tb_ioport_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ioport_bus_master_if if0 ();
  ioport_bus_master_if if3 ();

  ioport_bus_master #(.POST_GAP(0), .IWAIT_MAX(15)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  ioport_bus_master #(.POST_GAP(3), .IWAIT_MAX(15)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.master)
  );

  task automatic init_inputs();
    if0.cmd_valid = 1'b0; if0.cmd_op = 2'b00; if0.cmd_port = 8'h00; if0.cmd_data = 8'h00;
    if0.irq_en = 1'b0; if0.in_port = 8'h00; if0.interrupt = 1'b0;
    if3.cmd_valid = 1'b0; if3.cmd_op = 2'b00; if3.cmd_port = 8'h00; if3.cmd_data = 8'h00;
    if3.irq_en = 1'b0; if3.in_port = 8'h00; if3.interrupt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (if0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 0", if0.cmd_ready); end
    n_checks++; if (if0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", if0.rsp_valid); end
    n_checks++; if (if0.port_id !== 8'h00) begin n_fail++; $display("FAIL rst_port_id: got %h expected 00", if0.port_id); end
    n_checks++; if (if0.out_port !== 8'h00) begin n_fail++; $display("FAIL rst_out_port: got %h expected 00", if0.out_port); end
    n_checks++; if ({if0.read_strobe, if0.write_strobe, if0.k_write_strobe, if0.interrupt_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_strobes: got %b expected 0000", {if0.read_strobe, if0.write_strobe, if0.k_write_strobe, if0.interrupt_ack}); end
    n_checks++; if (if0.irq_count !== 8'h00) begin n_fail++; $display("FAIL rst_irq_count: got %h expected 00", if0.irq_count); end
    n_checks++; if (if0.irq_stuck !== 1'b0) begin n_fail++; $display("FAIL rst_irq_stuck: got %b expected 0", if0.irq_stuck); end
    n_checks++; if (if3.port_id !== 8'h00) begin n_fail++; $display("FAIL rst_port_id_gap3: got %h expected 00", if3.port_id); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", if0.cmd_ready); end
  endtask

  task automatic test_write();
    @(negedge clk);
    if0.cmd_valid = 1'b1; if0.cmd_op = 2'b01; if0.cmd_port = 8'h0A; if0.cmd_data = 8'h5C; #1;
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_t0: got %b expected 1", if0.cmd_ready); end
    @(negedge clk); if0.cmd_valid = 1'b0; #1;
    n_checks++; if (if0.port_id !== 8'h0A) begin n_fail++; $display("FAIL wr_port_id_t1: got %h expected 0a", if0.port_id); end
    n_checks++; if (if0.out_port !== 8'h5C) begin n_fail++; $display("FAIL wr_out_port_t1: got %h expected 5c", if0.out_port); end
    n_checks++; if (if0.write_strobe !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_t1: got %b expected 0", if0.write_strobe); end
    n_checks++; if (if0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_t1: got %b expected 0", if0.cmd_ready); end
    @(negedge clk); #1;
    n_checks++; if (if0.port_id !== 8'h0A) begin n_fail++; $display("FAIL wr_port_id_t2: got %h expected 0a", if0.port_id); end
    n_checks++; if (if0.out_port !== 8'h5C) begin n_fail++; $display("FAIL wr_out_port_t2: got %h expected 5c", if0.out_port); end
    n_checks++; if ({if0.read_strobe, if0.write_strobe, if0.k_write_strobe} !== 3'b010) begin
      n_fail++; $display("FAIL wr_strobes_t2: got %b expected 010", {if0.read_strobe, if0.write_strobe, if0.k_write_strobe}); end
    @(negedge clk); #1;
    n_checks++; if (if0.write_strobe !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_t3: got %b expected 0", if0.write_strobe); end
    n_checks++; if (if0.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid_t3: got %b expected 1", if0.rsp_valid); end
    n_checks++; if (if0.rsp_data !== 8'h00) begin n_fail++; $display("FAIL wr_rsp_data_t3: got %h expected 00", if0.rsp_data); end
    @(negedge clk); #1;
    n_checks++; if (if0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_valid_t4: got %b expected 0", if0.rsp_valid); end
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_t4: got %b expected 1", if0.cmd_ready); end
  endtask

  task automatic test_read();
    @(negedge clk);
    if0.cmd_valid = 1'b1; if0.cmd_op = 2'b00; if0.cmd_port = 8'h02; if0.cmd_data = 8'h99;
    @(negedge clk); if0.cmd_valid = 1'b0; #1;
    n_checks++; if (if0.port_id !== 8'h02) begin n_fail++; $display("FAIL rd_port_id_t1: got %h expected 02", if0.port_id); end
    n_checks++; if (if0.read_strobe !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_t1: got %b expected 0", if0.read_strobe); end
    @(negedge clk); if0.in_port = 8'hA7; #1;
    n_checks++; if ({if0.read_strobe, if0.write_strobe, if0.k_write_strobe} !== 3'b100) begin
      n_fail++; $display("FAIL rd_strobes_t2: got %b expected 100", {if0.read_strobe, if0.write_strobe, if0.k_write_strobe}); end
    @(negedge clk); if0.in_port = 8'h00; #1;
    n_checks++; if (if0.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid_t3: got %b expected 1", if0.rsp_valid); end
    n_checks++; if (if0.rsp_data !== 8'hA7) begin n_fail++; $display("FAIL rd_rsp_data_t3: got %h expected a7", if0.rsp_data); end
    n_checks++; if (if0.out_port !== 8'h5C) begin n_fail++; $display("FAIL rd_out_port_held: got %h expected 5c", if0.out_port); end
    n_checks++; if (if0.read_strobe !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_t3: got %b expected 0", if0.read_strobe); end
    @(negedge clk); #1;
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_t4: got %b expected 1", if0.cmd_ready); end
    n_checks++; if (if0.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rd_rsp_data_t4: got %h expected 00", if0.rsp_data); end
  endtask

  task automatic test_noop();
    @(negedge clk);
    if0.cmd_valid = 1'b1; if0.cmd_op = 2'b11; if0.cmd_port = 8'hFF; if0.cmd_data = 8'h11;
    @(negedge clk); if0.cmd_valid = 1'b0; #1;
    n_checks++; if (if0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL nop_rsp_valid_t1: got %b expected 0", if0.rsp_valid); end
    n_checks++; if (if0.port_id !== 8'h02) begin n_fail++; $display("FAIL nop_port_id_t1: got %h expected 02", if0.port_id); end
    @(negedge clk); #1;
    n_checks++; if (if0.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL nop_rsp_valid_t2: got %b expected 1", if0.rsp_valid); end
    n_checks++; if (if0.rsp_data !== 8'h00) begin n_fail++; $display("FAIL nop_rsp_data_t2: got %h expected 00", if0.rsp_data); end
    n_checks++; if ({if0.read_strobe, if0.write_strobe, if0.k_write_strobe} !== 3'b000) begin
      n_fail++; $display("FAIL nop_strobes_t2: got %b expected 000", {if0.read_strobe, if0.write_strobe, if0.k_write_strobe}); end
    n_checks++; if (if0.out_port !== 8'h5C) begin n_fail++; $display("FAIL nop_out_port_t2: got %h expected 5c", if0.out_port); end
    @(negedge clk); #1;
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL nop_ready_t3: got %b expected 1", if0.cmd_ready); end
  endtask

  task automatic test_const_gap();
    @(negedge clk);
    if3.cmd_valid = 1'b1; if3.cmd_op = 2'b10; if3.cmd_port = 8'h05; if3.cmd_data = 8'h0F; #1;
    n_checks++; if (if3.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL kw_ready_t0: got %b expected 1", if3.cmd_ready); end
    @(negedge clk); if3.cmd_valid = 1'b0; #1;
    n_checks++; if (if3.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL kw_ready_t1: got %b expected 0", if3.cmd_ready); end
    @(negedge clk); #1;
    n_checks++; if ({if3.read_strobe, if3.write_strobe, if3.k_write_strobe} !== 3'b001) begin
      n_fail++; $display("FAIL kw_strobes_t2: got %b expected 001", {if3.read_strobe, if3.write_strobe, if3.k_write_strobe}); end
    n_checks++; if ({if3.port_id, if3.out_port} !== 16'h050F) begin
      n_fail++; $display("FAIL kw_bus_t2: got %h expected 050f", {if3.port_id, if3.out_port}); end
    n_checks++; if (if3.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL kw_ready_t2: got %b expected 0", if3.cmd_ready); end
    @(negedge clk); #1;
    n_checks++; if (if3.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL kw_rsp_valid_t3: got %b expected 1", if3.rsp_valid); end
    n_checks++; if (if3.k_write_strobe !== 1'b0) begin n_fail++; $display("FAIL kw_strobe_t3: got %b expected 0", if3.k_write_strobe); end
    n_checks++; if (if3.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL kw_ready_t3: got %b expected 0", if3.cmd_ready); end
    for (int i = 4; i <= 6; i++) begin
      @(negedge clk); #1;
      n_checks++; if (if3.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL kw_ready_gap_t%0d: got %b expected 0", i, if3.cmd_ready); end
      n_checks++; if (if3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL kw_rsp_gap_t%0d: got %b expected 0", i, if3.rsp_valid); end
    end
    @(negedge clk); #1;
    n_checks++; if (if3.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL kw_ready_t7: got %b expected 1", if3.cmd_ready); end
  endtask

  task automatic test_irq_priority();
    @(negedge clk);
    if0.irq_en = 1'b1; if0.interrupt = 1'b1;
    if0.cmd_valid = 1'b1; if0.cmd_op = 2'b01; if0.cmd_port = 8'h33; if0.cmd_data = 8'h44; #1;
    n_checks++; if (if0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL irq_ready_a0: got %b expected 0", if0.cmd_ready); end
    n_checks++; if (if0.irq_count !== 8'h00) begin n_fail++; $display("FAIL irq_count_a0: got %h expected 00", if0.irq_count); end
    @(negedge clk); #1;
    n_checks++; if (if0.interrupt_ack !== 1'b1) begin n_fail++; $display("FAIL irq_ack_a1: got %b expected 1", if0.interrupt_ack); end
    n_checks++; if (if0.port_id !== 8'h02) begin n_fail++; $display("FAIL irq_port_id_a1: got %h expected 02", if0.port_id); end
    @(negedge clk); #1;
    n_checks++; if (if0.interrupt_ack !== 1'b0) begin n_fail++; $display("FAIL irq_ack_a2: got %b expected 0", if0.interrupt_ack); end
    n_checks++; if (if0.irq_count !== 8'h01) begin n_fail++; $display("FAIL irq_count_a2: got %h expected 01", if0.irq_count); end
    n_checks++; if (if0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL irq_ready_a2: got %b expected 0", if0.cmd_ready); end
    @(negedge clk); if0.interrupt = 1'b0; #1;
    n_checks++; if ({if0.cmd_ready, if0.interrupt_ack} !== 2'b00) begin
      n_fail++; $display("FAIL irq_iwait_a3: got %b expected 00", {if0.cmd_ready, if0.interrupt_ack}); end
    @(negedge clk); #1;
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL irq_ready_a4: got %b expected 1", if0.cmd_ready); end
    @(negedge clk); if0.cmd_valid = 1'b0; #1;
    n_checks++; if ({if0.port_id, if0.out_port} !== 16'h3344) begin
      n_fail++; $display("FAIL irq_retry_bus_a5: got %h expected 3344", {if0.port_id, if0.out_port}); end
    @(negedge clk); #1;
    n_checks++; if (if0.write_strobe !== 1'b1) begin n_fail++; $display("FAIL irq_retry_strobe_a6: got %b expected 1", if0.write_strobe); end
    @(negedge clk); #1;
    n_checks++; if (if0.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL irq_retry_rsp_a7: got %b expected 1", if0.rsp_valid); end
    n_checks++; if (if0.irq_count !== 8'h01) begin n_fail++; $display("FAIL irq_count_a7: got %h expected 01", if0.irq_count); end
    @(negedge clk);
    if0.irq_en = 1'b0;
  endtask

  task automatic test_stuck_irq();
    int acks;
    acks = 0;
    do_reset();
    @(negedge clk);
    if0.irq_en = 1'b1; if0.interrupt = 1'b1; #1;
    n_checks++; if (if0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stuck_ready_a0: got %b expected 0", if0.cmd_ready); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      if (if0.interrupt_ack === 1'b1) acks++;
    end
    n_checks++; if (if0.irq_stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_flag_a16: got %b expected 0", if0.irq_stuck); end
    n_checks++; if (if0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stuck_ready_a16: got %b expected 0", if0.cmd_ready); end
    @(negedge clk); #1;
    n_checks++; if (if0.irq_stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_flag_a17: got %b expected 1", if0.irq_stuck); end
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL stuck_ready_a17: got %b expected 1", if0.cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (if0.interrupt_ack === 1'b1) acks++;
    end
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL stuck_ack_count: got %0d expected 1", acks); end
    n_checks++; if (if0.irq_count !== 8'h01) begin n_fail++; $display("FAIL stuck_irq_count: got %h expected 01", if0.irq_count); end
    n_checks++; if (if0.irq_stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_flag_sticky: got %b expected 1", if0.irq_stuck); end
    if0.interrupt = 1'b0; if0.irq_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if0.cmd_valid = 1'b1; if0.cmd_op = 2'b01; if0.cmd_port = 8'h77; if0.cmd_data = 8'h88; #1;
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_t0: got %b expected 1", if0.cmd_ready); end
    @(negedge clk); if0.cmd_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (if0.write_strobe !== 1'b1) begin n_fail++; $display("FAIL rmid_strobe_t2: got %b expected 1", if0.write_strobe); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (if0.write_strobe !== 1'b0) begin n_fail++; $display("FAIL rmid_strobe_t3: got %b expected 0", if0.write_strobe); end
    n_checks++; if ({if0.port_id, if0.out_port} !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_bus_t3: got %h expected 0000", {if0.port_id, if0.out_port}); end
    n_checks++; if (if0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_t3: got %b expected 0", if0.rsp_valid); end
    n_checks++; if ({if0.irq_count, if0.irq_stuck} !== 9'h000) begin
      n_fail++; $display("FAIL rmid_irq_t3: got %h expected 000", {if0.irq_count, if0.irq_stuck}); end
    n_checks++; if (if0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_t3: got %b expected 1", if0.cmd_ready); end
    @(negedge clk); #1;
    n_checks++; if (if0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_t4: got %b expected 0", if0.rsp_valid); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_write();
    test_read();
    test_noop();
    test_const_gap();
    test_irq_priority();
    test_stuck_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ioport_bus_master.md
Name: ioport_bus_master

Overview:
Hardware initiator for the PicoBlaze-style 8-bit port bus (port_id / out_port / in_port / write_strobe / k_write_strobe / read_strobe / interrupt / interrupt_ack). It is the opposite end of the bot I/O interface block, which is a bus responder.
- Accepts read, write and constant-write commands on a valid/ready handshake.
- Runs each as a two-cycle KCPSM6-timed bus cycle and returns a one-cycle response.
- Acknowledges responder interrupts.
- Used as a hardware autopilot/debug master in place of the soft CPU, and as a bus driver in testbenches.

Parameters:
POST_GAP, 0, idle cycles inserted after each response before cmd_ready can re-assert (0..15).
IWAIT_MAX, 15, maximum cycles to wait for the interrupt to drop after acknowledge (1..255).

Ports:
clk  in  1  system clock (100 MHz).
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_op  in  2  00 read, 01 write, 10 constant write, 11 no-op.
cmd_port  in  8  target port address.
cmd_data  in  8  write data.
rsp_valid  out  1  one-cycle response pulse.
rsp_data  out  8  read data; 0 for non-read ops.
irq_en  in  1  enables interrupt servicing.
port_id  out  8  bus port address.
out_port  out  8  bus write data.
in_port  in  8  bus read data from responder.
write_strobe  out  1  write strobe.
k_write_strobe  out  1  constant-write strobe.
read_strobe  out  1  read strobe.
interrupt  in  1  interrupt request from responder, level.
interrupt_ack  out  1  interrupt acknowledge pulse.
irq_count  out  8  number of interrupts acknowledged, saturating.
irq_stuck  out  1  sticky flag: interrupt did not drop within IWAIT_MAX cycles.

Behaviour:
Reset and common rules:
- Every output resets to 0. The state machine resets to IDLE.
- All registers update on the rising edge of clk. rst has priority over everything, including a transaction in flight: no rsp_valid is issued, and strobes drop on the next edge.

States:
- IDLE, ADDR, STRB, RESP, GAP, IACK, IWAIT.

cmd_ready:
- cmd_ready = (state==IDLE) & ~irq_take.
- irq_take = irq_en & interrupt & ~irq_stuck.
- irq_take is combinational from interrupt and irq_en.

IDLE:
- If irq_take: go to IACK, even if cmd_valid is high. The command is not accepted and is retried later.
- Else if cmd_valid: latch op/port/data and go to ADDR.

ADDR (cycle T+1 after acceptance at T):
- port_id <= cmd_port. For write and constant write, out_port <= cmd_data.
- All strobes are 0.
- No-op goes directly to RESP and drives no bus signals.

STRB (T+2):
- port_id and out_port are held.
- Exactly one strobe is high for this single cycle, selected by op: read → read_strobe, write → write_strobe, constant write → k_write_strobe.
- For a read, in_port is captured at the end of this cycle.

RESP (T+3):
- rsp_valid=1 for one cycle.
- rsp_data is the captured in_port for a read, otherwise 0.
- Next state is GAP if POST_GAP>0, else IDLE.

GAP:
- Counts POST_GAP cycles, then goes to IDLE.
- Back-to-back transaction period is 4+POST_GAP cycles.

Bus hold after a transaction:
- port_id and out_port hold their last values after the transaction, matching KCPSM6 behaviour.
- A read does not modify out_port.

IACK:
- interrupt_ack=1 for exactly one cycle.
- irq_count increments, saturating at 255.
- Go to IWAIT with the wait counter cleared.

IWAIT:
- If interrupt is low, go to IDLE.
- Else the counter increments. When it reaches IWAIT_MAX with interrupt still high, set irq_stuck and go to IDLE.
- This prevents a level interrupt from re-triggering before it is released.

irq_stuck:
- Sticky; cleared only by rst.
- While set, interrupts are ignored.

Timing and ordering rules:
- Interrupts are serviced only from IDLE. An interrupt arriving mid-transaction waits until the master returns to IDLE.
- irq_en falling during IACK or IWAIT does not abort the sequence.
- cmd inputs are ignored outside the IDLE acceptance cycle.

Test Plan:
1. Write: cmd op=01, port=0x0A, data=0x5C accepted at T → port_id=0x0A and out_port=0x5C at T+1 and T+2; write_strobe high only at T+2; rsp_valid at T+3 with rsp_data=0x00; cmd_ready high at T+4 (POST_GAP=0).
2. Read: op=00, port=0x02, in_port=0xA7 during T+2 → read_strobe high only at T+2; rsp_data=0xA7 at T+3; out_port unchanged from previous value 0x5C.
3. Constant write plus gap, POST_GAP=3: op=10, port=0x05, data=0x0F → k_write_strobe high only at T+2; cmd_ready stays low T+1..T+6 and re-asserts at T+7.
4. Interrupt priority: interrupt=1 and cmd_valid=1 together in IDLE with irq_en=1 → cmd_ready=0; interrupt_ack pulses one cycle; irq_count goes 0→1; responder drops interrupt 2 cycles later → master returns to IDLE and the pending command is accepted next.
5. Stuck interrupt: interrupt held high, IWAIT_MAX=15 → exactly one interrupt_ack; irq_stuck=1 after 15 IWAIT cycles; afterwards cmd_ready=1 while interrupt is still high; irq_count stays at 1.
6. Reset mid-operation: assert rst for one cycle while in STRB of a write → write_strobe, port_id and out_port are 0 on the next edge; no rsp_valid; irq_count=0; cmd_ready=1 the cycle after rst deasserts.
